// File: rtl/dot_seq_pkg.sv
// Shared types and constants for the dot-product job sequencer.
package dot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A_ADDR,
    RD_A_DATA,
    RD_B_ADDR,
    RD_B_DATA,
    WR,
    WR_RESP,
    DONE
  } state_t;

  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam int         ADDR_STRIDE = 4;

endpackage

// File: rtl/dot_mac_acc.sv
// Multiply-accumulate datapath: holds the A operand of the current element and
// a wrapping accumulator that adds A*B (truncated) when enabled.
module dot_mac_acc
  import dot_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load_a,
  input  logic [DATA_W-1:0] a_in,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] acc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg   <= '0;
      acc_reg <= '0;
    end else if (clear) begin
      a_reg   <= '0;
      acc_reg <= '0;
    end else begin
      if (load_a) begin
        a_reg <= a_in;
      end
      // Product and sum both truncate to DATA_W, giving modulo-2^DATA_W wrap.
      if (acc_en) begin
        acc_reg <= acc_reg + a_reg * b_in;
      end
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/dot_seq_ctrl.sv
// Dot-product job sequencer: fetches A[i]/B[i] over AXI-Lite reads, accumulates
// the products and writes the final sum back over the AXI-Lite write channel.
module dot_seq_ctrl
  import dot_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [ADDR_W-1:0]   out_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   result,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t state_reg;
  state_t state_next;

  logic [ADDR_W-1:0] a_base_reg;
  logic [ADDR_W-1:0] b_base_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic              err_reg;
  logic [DATA_W-1:0] result_reg;
  logic              aw_done_reg;
  logic              w_done_reg;

  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] idx_offset;
  logic              last_elem;
  logic              r_ok;
  logic              mac_clear;
  logic              mac_load_a;
  logic              mac_acc_en;

  assign idx_offset = ADDR_W'(idx_reg) * ADDR_W'(ADDR_STRIDE);
  assign last_elem  = (idx_reg == len_reg - LEN_W'(1));
  assign r_ok       = (rresp == AXI_OKAY);

  assign mac_clear  = (state_reg == IDLE) && start;
  assign mac_load_a = (state_reg == RD_A_DATA) && rvalid && r_ok;
  assign mac_acc_en = (state_reg == RD_B_DATA) && rvalid && r_ok;

  dot_mac_acc #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .load_a (mac_load_a),
    .a_in   (rdata),
    .acc_en (mac_acc_en),
    .b_in   (rdata),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_base_reg   <= '0;
      b_base_reg   <= '0;
      out_addr_reg <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
      err_reg      <= 1'b0;
      result_reg   <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_base_reg   <= a_addr;
            b_base_reg   <= b_addr;
            out_addr_reg <= out_addr;
            len_reg      <= len;
            idx_reg      <= '0;
            err_reg      <= 1'b0;
            result_reg   <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
          end
        end
        RD_A_DATA: begin
          if (rvalid && !r_ok) begin
            err_reg <= 1'b1;
          end
        end
        RD_B_DATA: begin
          if (rvalid) begin
            if (!r_ok) begin
              err_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + LEN_W'(1);
            end
          end
        end
        WR: begin
          // AW and W retire independently; remember which one has already gone.
          if (awvalid && awready) begin
            aw_done_reg <= 1'b1;
          end
          if (wvalid && wready) begin
            w_done_reg <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            result_reg <= acc;
            if (bresp != AXI_OKAY) begin
              err_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    araddr     = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awaddr     = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wvalid     = 1'b0;
    bready     = 1'b0;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (len == '0) ? WR : RD_A_ADDR;
        end
      end
      RD_A_ADDR: begin
        arvalid = 1'b1;
        araddr  = a_base_reg + idx_offset;
        if (arready) begin
          state_next = RD_A_DATA;
        end
      end
      RD_A_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          state_next = r_ok ? RD_B_ADDR : DONE;
        end
      end
      RD_B_ADDR: begin
        arvalid = 1'b1;
        araddr  = b_base_reg + idx_offset;
        if (arready) begin
          state_next = RD_B_DATA;
        end
      end
      RD_B_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (!r_ok) begin
            state_next = DONE;
          end else if (last_elem) begin
            state_next = WR;
          end else begin
            state_next = RD_A_ADDR;
          end
        end
      end
      WR: begin
        awaddr  = out_addr_reg;
        wdata   = acc;
        wstrb   = '1;
        awvalid = !aw_done_reg;
        wvalid  = !w_done_reg;
        if ((aw_done_reg || awready) && (w_done_reg || wready)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign err    = err_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Bench for dot_seq_ctrl: AXI-Lite slave with optional random backpressure and
// a sum-of-products reference model computed directly from the memory image.
module tb_dot_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   a_addr = '0;
  logic [ADDR_W-1:0]   b_addr = '0;
  logic [ADDR_W-1:0]   out_addr = '0;
  logic [LEN_W-1:0]    len = '0;
  logic                busy;
  logic                done;
  logic                err;
  logic [DATA_W-1:0]   result;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready = 1'b0;
  logic [DATA_W-1:0]   rdata = '0;
  logic [1:0]          rresp = 2'b00;
  logic                rvalid = 1'b0;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready = 1'b0;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready = 1'b0;
  logic [1:0]          bresp = 2'b00;
  logic                bvalid = 1'b0;
  logic                bready;

  dot_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_addr(a_addr), .b_addr(b_addr), .out_addr(out_addr), .len(len),
    .busy(busy), .done(done), .err(err), .result(result),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory image and controls written by the main sequence, read by the slave.
  logic [31:0] mem [logic [31:0]];
  bit bp_mode = 1'b0;
  int err_on_read = 0;
  int job_id = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] ad);
    return mem.exists(ad) ? mem[ad] : 32'h0;
  endfunction

  function automatic int dly();
    return bp_mode ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Slave state and transaction logs.
  int last_job = -1;
  int rd_num = 0;
  bit rd_err_now = 1'b0;
  bit rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit aw_got = 1'b0, w_got = 1'b0;
  bit ar_fire = 1'b0, r_fire = 1'b0, aw_fire = 1'b0, w_fire = 1'b0, b_fire = 1'b0;
  bit ar_wait = 1'b0, aw_wait = 1'b0, w_wait = 1'b0;
  logic [31:0] ar_hold = '0, aw_hold = '0, w_hold = '0;
  logic [31:0] rd_log[$];
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int aw_cyc_log[$];
  int w_cyc_log[$];
  int done_cnt = 0;

  task automatic reload_cnts();
    ar_cnt = dly();
    r_cnt  = dly();
    b_cnt  = dly();
    aw_cnt = dly();
    // W readiness always differs from AW so the two handshakes split under backpressure.
    w_cnt  = bp_mode ? (aw_cnt + 1 + int'($urandom_range(0, 3))) % 6 : 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rresp = 2'b00; bresp = 2'b00;
      rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      ar_fire = 1'b0; r_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
      ar_wait = 1'b0; aw_wait = 1'b0; w_wait = 1'b0;
    end else begin
      if (job_id != last_job) begin
        last_job = job_id;
        rd_num = 0;
        reload_cnts();
      end
      if (done) done_cnt++;
      if (ar_wait) begin
        check("ar_valid_held", arvalid, 1);
        check("ar_addr_stable", araddr, ar_hold);
      end
      if (aw_wait) begin
        check("aw_valid_held", awvalid, 1);
        check("aw_addr_stable", awaddr, aw_hold);
      end
      if (w_wait) begin
        check("w_valid_held", wvalid, 1);
        check("w_data_stable", wdata, w_hold);
      end
      // Retire handshakes that completed on the preceding rising edge.
      if (r_fire) begin
        rvalid = 1'b0; rresp = 2'b00; rd_pend = 1'b0;
      end
      if (ar_fire) begin
        arready = 1'b0;
        rd_log.push_back(ar_hold);
        rd_addr = ar_hold;
        rd_pend = 1'b1;
        rd_num++;
        rd_err_now = (rd_num == err_on_read);
        ar_cnt = dly();
        r_cnt = dly();
      end
      if (aw_fire) begin
        awready = 1'b0; aw_got = 1'b1; aw_log.push_back(aw_hold);
      end
      if (w_fire) begin
        wready = 1'b0; w_got = 1'b1; w_log.push_back(w_hold);
      end
      if (b_fire) begin
        bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        reload_cnts();
      end
      // Drive responses for this cycle.
      if (arvalid && !arready) begin
        if (ar_cnt == 0) arready = 1'b1; else ar_cnt--;
      end
      if (rd_pend && !rvalid) begin
        if (r_cnt == 0) begin
          rvalid = 1'b1;
          rdata = mem_rd(rd_addr);
          rresp = rd_err_now ? 2'b10 : 2'b00;
        end else r_cnt--;
      end
      if (awvalid && !awready && !aw_got) begin
        if (aw_cnt == 0) awready = 1'b1; else aw_cnt--;
      end
      if (wvalid && !wready && !w_got) begin
        if (w_cnt == 0) wready = 1'b1; else w_cnt--;
      end
      if (aw_got && w_got && !bvalid) begin
        if (b_cnt == 0) begin bvalid = 1'b1; bresp = 2'b00; end else b_cnt--;
      end
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      if (w_fire) check("wstrb", wstrb, 4'hF);
      if (aw_fire) aw_cyc_log.push_back(cyc);
      if (w_fire) w_cyc_log.push_back(cyc);
      ar_wait = arvalid && !arready;  ar_hold = araddr;
      aw_wait = awvalid && !awready;  aw_hold = awaddr;
      w_wait  = wvalid && !wready;    w_hold  = wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill(input logic [31:0] base, input int i, input logic [31:0] v);
    mem[base + 32'(4 * i)] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":arvalid"}, arvalid, 0);
    check({tag, ":araddr"}, araddr, 0);
    check({tag, ":rready"}, rready, 0);
    check({tag, ":awvalid"}, awvalid, 0);
    check({tag, ":wvalid"}, wvalid, 0);
    check({tag, ":wstrb"}, wstrb, 0);
    check({tag, ":bready"}, bready, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":done"}, done, 0);
    check({tag, ":err"}, err, 0);
    check({tag, ":result"}, result, 0);
  endtask

  task automatic run_job(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o, input int n, input int err_rd,
                         input bit bp, input bit poke_start);
    int t0, rd0, aw0, w0, awc0, wc0, d0, nreads, lat;
    bit got;
    logic [31:0] exp_acc, ea;
    bp_mode = bp;
    err_on_read = err_rd;
    job_id++;
    a_addr = a; b_addr = b; out_addr = o; len = LEN_W'(n);
    rd0 = rd_log.size(); aw0 = aw_log.size(); w0 = w_log.size();
    awc0 = aw_cyc_log.size(); wc0 = w_cyc_log.size(); d0 = done_cnt;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    a_addr = $urandom; b_addr = $urandom; out_addr = $urandom; len = LEN_W'($urandom);
    check({name, ":busy@T+1"}, busy, 1);
    check({name, ":err@T+1"}, err, 0);
    check({name, ":result@T+1"}, result, 0);
    check({name, ":arvalid@T+1"}, arvalid, (n != 0) ? 1 : 0);
    check({name, ":awvalid@T+1"}, awvalid, (n == 0) ? 1 : 0);
    got = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (poke_start && k == 2) begin
        start = 1'b1; len = LEN_W'(1); a_addr = 32'h900; out_addr = 32'h990;
      end
      if (poke_start && k == 3) start = 1'b0;
      if (done) begin got = 1'b1; break; end
      step();
    end
    start = 1'b0;
    lat = cyc - t0;
    check({name, ":done_seen"}, got, 1);
    check({name, ":busy@done"}, busy, 0);
    step();
    check({name, ":done_pulses"}, done_cnt - d0, 1);
    check({name, ":done_low"}, done, 0);

    exp_acc = '0;
    for (int i = 0; i < n; i++)
      exp_acc = exp_acc + mem_rd(a + 32'(4 * i)) * mem_rd(b + 32'(4 * i));
    nreads = (err_rd != 0) ? err_rd : 2 * n;
    check({name, ":n_reads"}, rd_log.size() - rd0, nreads);
    for (int r = 0; r < nreads; r++) begin
      ea = ((r % 2) ? b : a) + 32'(4 * (r / 2));
      if (rd_log.size() > rd0 + r) check({name, ":rd_addr"}, rd_log[rd0 + r], ea);
    end
    if (err_rd != 0) begin
      check({name, ":err"}, err, 1);
      check({name, ":n_aw"}, aw_log.size() - aw0, 0);
      check({name, ":n_w"}, w_log.size() - w0, 0);
      check({name, ":result"}, result, 0);
    end else begin
      check({name, ":err"}, err, 0);
      check({name, ":n_aw"}, aw_log.size() - aw0, 1);
      check({name, ":n_w"}, w_log.size() - w0, 1);
      if (aw_log.size() > aw0) check({name, ":awaddr"}, aw_log[aw0], o);
      if (w_log.size() > w0) check({name, ":wdata"}, w_log[w0], exp_acc);
      check({name, ":result"}, result, exp_acc);
      if (!bp) check({name, ":latency"}, lat, (n == 0) ? 3 : 4 * n + 3);
      if (bp && aw_cyc_log.size() > awc0 && w_cyc_log.size() > wc0)
        check({name, ":aw_w_split"}, aw_cyc_log[awc0] != w_cyc_log[wc0], 1);
    end
    $display("[TB] job %s len=%0d bp=%0b result=0x%08h err=%0b latency=%0d",
             name, n, bp, result, err, lat);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb, ro;
    int rn, re;
    bit rbp;

    rst = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b1;
    step();
    check_idle_outputs("post_reset");

    fill(32'h10, 0, 8); fill(32'h10, 1, 1); fill(32'h10, 2, 5);
    fill(32'h20, 0, 6); fill(32'h20, 1, 5); fill(32'h20, 2, 3);
    run_job("basic", 32'h10, 32'h20, 32'h30, 3, 0, 1'b0, 1'b0);
    check("basic:value", result, 32'h44);

    run_job("len0", 32'h0, 32'h0, 32'h70, 0, 0, 1'b0, 1'b0);

    fill(32'h100, 0, 7); fill(32'h100, 1, 3); fill(32'h100, 2, 6);
    fill(32'h200, 0, 4); fill(32'h200, 1, 2); fill(32'h200, 2, 4);
    run_job("backpressure", 32'h100, 32'h200, 32'h300, 3, 0, 1'b1, 1'b0);
    check("backpressure:value", result, 32'h3A);

    fill(32'h400, 0, 32'hFFFF_FFFF); fill(32'h400, 1, 2);
    fill(32'h500, 0, 2); fill(32'h500, 1, 1);
    run_job("overflow", 32'h400, 32'h500, 32'h600, 2, 0, 1'b0, 1'b0);
    check("overflow:value", result, 32'h0);

    run_job("slverr", 32'h10, 32'h20, 32'h30, 3, 2, 1'b0, 1'b0);
    run_job("after_err", 32'h10, 32'h20, 32'h34, 3, 0, 1'b0, 1'b0);

    run_job("start_busy", 32'h100, 32'h200, 32'h304, 3, 0, 1'b0, 1'b1);

    // Reset asserted while the first B word is being returned.
    job_id++;
    bp_mode = 1'b0; err_on_read = 0;
    a_addr = 32'h10; b_addr = 32'h20; out_addr = 32'h30; len = LEN_W'(3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("midreset:rready@T+4", rready, 1);
    begin
      int d0;
      d0 = done_cnt;
      rst = 1'b0;
      step();
      check_idle_outputs("midreset");
      rst = 1'b1;
      repeat (4) step();
      check("midreset:no_done", done_cnt - d0, 0);
    end
    run_job("restart", 32'h10, 32'h20, 32'h30, 3, 0, 1'b0, 1'b0);

    fill(32'hFFFF_FFF8, 0, 32'h11); fill(32'hFFFF_FFF8, 1, 32'h22);
    fill(32'hFFFF_FFF8, 2, 32'h33);
    fill(32'h800, 0, 3); fill(32'h800, 1, 4); fill(32'h800, 2, 5);
    run_job("addr_wrap", 32'hFFFF_FFF8, 32'h800, 32'h40, 3, 0, 1'b1, 1'b0);

    for (int j = 0; j < 8; j++) begin
      ra  = ($urandom & 32'h0000_FFFC) | 32'h1_0000;
      rb  = ($urandom & 32'h0000_FFFC) | 32'h2_0000;
      ro  = $urandom & 32'hFFFF_FFFC;
      rn  = int'($urandom_range(1, 6));
      rbp = 1'($urandom_range(0, 1));
      re  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * rn)) : 0;
      for (int i = 0; i < rn; i++) begin
        fill(ra, i, $urandom);
        fill(rb, i, $urandom);
      end
      run_job($sformatf("rand%0d", j), ra, rb, ro, rn, re, rbp, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
